// File: rtl/clock_switch_seq.sv
// rtl/clock_switch_seq.sv - break-before-make ICG enable sequencer for the glitch-free clock switch
// Optional source-acknowledge handshake with timeout: define CLKSW_ACK_EN.
module clock_switch_seq #(
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int OFF_CYC = 4,
  parameter int ON_CYC  = 4,
  parameter int RST_SEL = 0,
  parameter int CNT_W   = 4
`ifdef CLKSW_ACK_EN
  ,
  parameter int TMO_CYC = 15
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
`ifdef CLKSW_ACK_EN
  input  logic [NUM_SRC-1:0] src_ack,
`endif
  output logic               req_ready,
  output logic [NUM_SRC-1:0] gate_en,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_OFF, S_ON, S_DONE} state_t;

  localparam logic [CNT_W-1:0]   OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0]   ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [NUM_SRC-1:0] GATE_RST = NUM_SRC'(1) << RST_SEL;
  localparam logic [SEL_W-1:0]   SEL_RST  = SEL_W'(RST_SEL);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   tgt, tgt_nxt, cur_nxt;
  logic [NUM_SRC-1:0] gate_nxt;
  logic               err_nxt;

`ifdef CLKSW_ACK_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [NUM_SRC-1:0] ack_m, ack_s;
  logic [TW-1:0]      wcnt, wcnt_nxt;
  logic               acked, acked_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= '0;
      ack_s <= '0;
      wcnt  <= '0;
      acked <= 1'b0;
    end else begin
      ack_m <= src_ack;
      ack_s <= ack_m;
      wcnt  <= wcnt_nxt;
      acked <= acked_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    cur_nxt   = cur_sel;
    gate_nxt  = gate_en;
    err_nxt   = 1'b0;
`ifdef CLKSW_ACK_EN
    wcnt_nxt  = wcnt;
    acked_nxt = acked;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (32'(req_sel) >= NUM_SRC) begin
            err_nxt = 1'b1;
          end else begin
            tgt_nxt = req_sel;
            cnt_nxt = '0;
            if (req_sel == cur_sel) begin
              state_nxt = S_DONE;
              cur_nxt   = req_sel;
            end else begin
              state_nxt = S_OFF;
              gate_nxt  = '0;
`ifdef CLKSW_ACK_EN
              wcnt_nxt  = '0;
`endif
            end
          end
        end
      end
      S_OFF: begin
`ifdef CLKSW_ACK_EN
        // Count saturates at OFF_LAST, then waits for the old source to report stopped.
        if (cnt != OFF_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else if (!ack_s[cur_sel] || wcnt == TMO_LAST) begin
          err_nxt   = ack_s[cur_sel];
          state_nxt = S_ON;
          cnt_nxt   = '0;
          wcnt_nxt  = '0;
          acked_nxt = 1'b0;
          gate_nxt  = NUM_SRC'(1) << tgt;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
`else
        if (cnt == OFF_LAST) begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
          gate_nxt  = NUM_SRC'(1) << tgt;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_ON: begin
`ifdef CLKSW_ACK_EN
        if (!acked) begin
          if (ack_s[tgt]) begin
            acked_nxt = 1'b1;
          end else if (wcnt == TMO_LAST) begin
            acked_nxt = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end else
`endif
        if (cnt == ON_LAST) begin
          state_nxt = S_DONE;
          cur_nxt   = tgt;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tgt       <= SEL_RST;
      cur_sel   <= SEL_RST;
      gate_en   <= GATE_RST;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tgt       <= tgt_nxt;
      cur_sel   <= cur_nxt;
      gate_en   <= gate_nxt;
      req_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clock_switch_seq.sv
// tb/tb_clock_switch_seq.sv - directed scoreboard bench for clock_switch_seq
module tb_clock_switch_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic [2:0] gate_en;
  logic [1:0] cur_sel;
  logic       busy, done, err;

  clock_switch_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .gate_en(gate_en), .cur_sel(cur_sel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [1:0] sel;
    logic [2:0] gate;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   vecs = 0;
  int   miss = 0;
  int   t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit is_err, input logic [1:0] sel, input logic [2:0] gate, input int at);
    exp_t e;
    e.is_err = is_err;
    e.sel    = sel;
    e.gate   = gate;
    e.at     = at;
    sb.push_back(e);
  endtask

  // Completion/error events are popped from the scoreboard as they appear.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("gate_onehot0", 32'($onehot0(gate_en)), 1);
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_evt", {done, err}, 0);
        end else begin
          m_e = sb.pop_front();
          chk("evt_err", err, m_e.is_err);
          chk("evt_done", done, !m_e.is_err);
          chk("evt_cycle", cyc, m_e.at);
          chk("evt_cur_sel", cur_sel, m_e.sel);
          chk("evt_gate", gate_en, m_e.gate);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 2'd0;
    nclk(2);
    chk("rst_gate", gate_en, 3'b001);
    chk("rst_cur", cur_sel, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    nclk(1);
    chk("post_rst_gate", gate_en, 3'b001);
    chk("post_rst_cur", cur_sel, 0);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_err", err, 0);

    // switch 0 -> 2
    req_sel = 2'd2; req_valid = 1'b1; t = cyc + 1;
    push(0, 2'd2, 3'b100, t + 8);
    for (int k = 1; k <= 10; k++) begin
      nclk(1);
      if (k == 1) req_valid = 1'b0;
      chk("sw02_gate", gate_en, (k <= 4) ? 3'b000 : 3'b100);
      chk("sw02_ready", req_ready, k == 10);
    end
    chk("sw02_cur", cur_sel, 2);

    // same-source request
    req_sel = 2'd2; req_valid = 1'b1; t = cyc + 1;
    push(0, 2'd2, 3'b100, t);
    nclk(1); req_valid = 1'b0;
    chk("same_gate1", gate_en, 3'b100);
    chk("same_ready1", req_ready, 0);
    nclk(1);
    chk("same_gate2", gate_en, 3'b100);
    chk("same_ready2", req_ready, 1);
    chk("same_busy2", busy, 0);

    // illegal select
    req_sel = 2'd3; req_valid = 1'b1; t = cyc + 1;
    push(1, 2'd2, 3'b100, t);
    nclk(1); req_valid = 1'b0;
    chk("ill_ready", req_ready, 1);
    chk("ill_busy", busy, 0);
    chk("ill_gate", gate_en, 3'b100);
    chk("ill_cur", cur_sel, 2);
    nclk(1);
    chk("ill_err_once", err, 0);

    // back-to-back: second request held while busy
    req_sel = 2'd0; req_valid = 1'b1; t = cyc + 1;
    push(0, 2'd0, 3'b001, t + 8);
    push(0, 2'd1, 3'b010, t + 18);
    nclk(1);
    req_sel = 2'd1;
    for (int k = 2; k <= 11; k++) begin
      nclk(1);
      chk("b2b_ready", req_ready, k == 10);
    end
    req_valid = 1'b0;
    nclk(9);
    chk("b2b_ready_end", req_ready, 1);
    chk("b2b_cur", cur_sel, 1);
    chk("b2b_gate", gate_en, 3'b010);

    // reset during OFF phase
    req_sel = 2'd2; req_valid = 1'b1;
    nclk(1); req_valid = 1'b0;
    nclk(1);
    chk("mid_off_gate", gate_en, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gate", gate_en, 3'b001);
    chk("mid_rst_cur", cur_sel, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    nclk(1);
    rst_n = 1'b1;
    nclk(1);
    chk("after_rst_gate", gate_en, 3'b001);
    chk("after_rst_ready", req_ready, 1);

    // FSM back in IDLE: switch 0 -> 1 completes normally
    req_sel = 2'd1; req_valid = 1'b1; t = cyc + 1;
    push(0, 2'd1, 3'b010, t + 8);
    nclk(1); req_valid = 1'b0;
    nclk(10);
    chk("final_ready", req_ready, 1);
    chk("final_gate", gate_en, 3'b010);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
